// File: rtl/des_key_schedule.sv
// DES key schedule: expands a 64-bit key into subkeys K1..K16, RNDS_PER_CYC rounds per clock.
// Optional odd-parity key check enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_key_schedule #(
  parameter int RNDS_PER_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [0:63] key_in,
  output logic [0:47] key1,
  output logic [0:47] key2,
  output logic [0:47] key3,
  output logic [0:47] key4,
  output logic [0:47] key5,
  output logic [0:47] key6,
  output logic [0:47] key7,
  output logic [0:47] key8,
  output logic [0:47] key9,
  output logic [0:47] key10,
  output logic [0:47] key11,
  output logic [0:47] key12,
  output logic [0:47] key13,
  output logic [0:47] key14,
  output logic [0:47] key15,
  output logic [0:47] key16,
  output logic        keys_valid,
  output logic        busy
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic        parity_err
`endif
);

  if (!(RNDS_PER_CYC inside {1, 2, 4})) begin : g_bad_param
    $error("des_key_schedule: RNDS_PER_CYC must be 1, 2 or 4");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Table entries are FIPS bit numbers (1 = MSB).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[i] = k[PC1[i]-1];
    return r;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:27] c, input logic [0:27] d);
    logic [0:55] cd;
    logic [0:47] r;
    cd = {c, d};
    r  = '0;
    for (int i = 0; i < 48; i++) r[i] = cd[PC2[i]-1];
    return r;
  endfunction

  function automatic logic [0:27] rotl(input logic [0:27] v, input logic two);
    return two ? {v[2:27], v[0:1]} : {v[1:27], v[0]};
  endfunction

  logic [1:0]  state;
  logic [0:27] c_q, d_q, c_nxt, d_nxt;
  logic [3:0]  rnd_q;
  logic [0:47] subkey [16];
  logic [0:47] rkey   [RNDS_PER_CYC];
  logic [3:0]  ridx   [RNDS_PER_CYC];
  logic        last_cyc;

  // Chain RNDS_PER_CYC rounds; rnd_q counts rounds already done, so round r has index r-1.
  always_comb begin
    logic [0:27] c, d;
    logic [3:0]  idx;
    c = c_q;
    d = d_q;
    for (int j = 0; j < RNDS_PER_CYC; j++) begin
      idx     = rnd_q + 4'(j);
      ridx[j] = idx;
      c       = rotl(c, !(idx inside {4'd0, 4'd1, 4'd8, 4'd15}));
      d       = rotl(d, !(idx inside {4'd0, 4'd1, 4'd8, 4'd15}));
      rkey[j] = pc2(c, d);
    end
    c_nxt = c;
    d_nxt = d;
  end

  assign last_cyc = (rnd_q == 4'(16 - RNDS_PER_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c_q   <= '0;
      d_q   <= '0;
      rnd_q <= '0;
      for (int i = 0; i < 16; i++) subkey[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (key_valid) begin
            {c_q, d_q} <= pc1(key_in);
            rnd_q      <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          c_q   <= c_nxt;
          d_q   <= d_nxt;
          rnd_q <= rnd_q + 4'(RNDS_PER_CYC);
          for (int j = 0; j < RNDS_PER_CYC; j++) subkey[ridx[j]] <= rkey[j];
          if (last_cyc) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  // DES keys carry odd parity per byte; an even byte flags the key but does not stop the schedule.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (key_valid && state != RUN) begin
      parity_err <= 1'b0;
      for (int b = 0; b < 8; b++)
        if (!(^key_in[8*b +: 8])) parity_err <= 1'b1;
    end
  end
`else
  logic unused_parity_bits;
  assign unused_parity_bits = ^{key_in[7], key_in[15], key_in[23], key_in[31],
                                key_in[39], key_in[47], key_in[55], key_in[63]};
`endif

  assign key_ready  = (state != RUN);
  assign busy       = (state == RUN);
  assign keys_valid = (state == DONE);

  assign key1  = subkey[0];
  assign key2  = subkey[1];
  assign key3  = subkey[2];
  assign key4  = subkey[3];
  assign key5  = subkey[4];
  assign key6  = subkey[5];
  assign key7  = subkey[6];
  assign key8  = subkey[7];
  assign key9  = subkey[8];
  assign key10 = subkey[9];
  assign key11 = subkey[10];
  assign key12 = subkey[11];
  assign key13 = subkey[12];
  assign key14 = subkey[13];
  assign key15 = subkey[14];
  assign key16 = subkey[15];

endmodule
